// File: rtl/vga_timing_receiver.sv
// Sink-side VGA timing recovery: rebuilds pixel coordinates from HS/VS/BLANK,
// measures line/frame timing and reports lock once it is stable.
module vga_timing_receiver #(
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 10
) (
    input  logic          vga_clock,
    input  logic          reset,
    input  logic          VGA_HS,
    input  logic          VGA_VS,
    input  logic          VGA_BLANK,
    input  logic [7:0]    VGA_R,
    input  logic [7:0]    VGA_G,
    input  logic [7:0]    VGA_B,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          pixel_valid,
    output logic [23:0]   pixel,
    output logic          frame_start,
    output logic          locked,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_active,
    output logic [7:0]    err_count
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        VERIFY  = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [CW-1:0] C_ZERO = '0;
    localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_MAX  = '1;
    localparam logic [7:0]    LOCK_N = 8'(LOCK_FRAMES);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == C_MAX) ? v : v + C_ONE;
    endfunction

    logic          hs1_r, vs1_r, bl1_r, hs2_r, vs2_r;
    logic [23:0]   rgb1_r;
    logic [CW-1:0] hcnt_r, acnt_r, vcnt_r, lcnt_r;
    logic [CW-1:0] line_len_r, first_act_r;
    logic          first_seen_r;
    state_t        state_r, state_n_s;
    logic [7:0]    mcnt_r, mcnt_n_s;
    logic          err_inc_s, latch_s;
    logic          hs_fall_s, vs_fall_s, bl_fall_s, act_nz_s, sat_s;
    logic          line_bad_s, frame_bad_s;
    logic [CW-1:0] line_len_s, line_act_s;

    // pixel_valid doubles as the stage-2 copy of BLANK
    assign hs_fall_s   = hs2_r & ~hs1_r;
    assign vs_fall_s   = vs2_r & ~vs1_r;
    assign bl_fall_s   = pixel_valid & ~bl1_r;
    assign line_len_s  = sat_inc(hcnt_r);
    assign line_act_s  = bl1_r ? sat_inc(acnt_r) : acnt_r;
    assign act_nz_s    = (line_act_s != C_ZERO);
    assign sat_s       = (hcnt_r == C_MAX) || (vcnt_r == C_MAX);
    assign line_bad_s  = hs_fall_s && ((line_len_s != h_total) ||
                                       (act_nz_s && (line_act_s != h_active)));
    assign frame_bad_s = vs_fall_s && ((vcnt_r != v_total) || (lcnt_r != v_active));

    // Input register stage plus stage-2 copies for edge detection
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            hs1_r       <= 1'b0;
            vs1_r       <= 1'b0;
            bl1_r       <= 1'b0;
            rgb1_r      <= 24'd0;
            hs2_r       <= 1'b0;
            vs2_r       <= 1'b0;
            pixel_valid <= 1'b0;
            pixel       <= 24'd0;
        end else begin
            hs1_r       <= VGA_HS;
            vs1_r       <= VGA_VS;
            bl1_r       <= VGA_BLANK;
            rgb1_r      <= {VGA_R, VGA_G, VGA_B};
            hs2_r       <= hs1_r;
            vs2_r       <= vs1_r;
            pixel_valid <= bl1_r;
            pixel       <= rgb1_r;
        end
    end

    // Line and frame measurement counters
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            hcnt_r       <= C_ZERO;
            acnt_r       <= C_ZERO;
            vcnt_r       <= C_ZERO;
            lcnt_r       <= C_ZERO;
            line_len_r   <= C_ZERO;
            first_act_r  <= C_ZERO;
            first_seen_r <= 1'b0;
        end else begin
            if (hs_fall_s) begin
                hcnt_r     <= C_ZERO;
                acnt_r     <= C_ZERO;
                line_len_r <= line_len_s;
            end else begin
                hcnt_r <= sat_inc(hcnt_r);
                acnt_r <= bl1_r ? sat_inc(acnt_r) : acnt_r;
            end
            // a line ending on the VS edge is credited to the new frame
            if (vs_fall_s) begin
                vcnt_r       <= hs_fall_s ? C_ONE : C_ZERO;
                lcnt_r       <= (hs_fall_s && act_nz_s) ? C_ONE : C_ZERO;
                first_seen_r <= hs_fall_s && act_nz_s;
                first_act_r  <= (hs_fall_s && act_nz_s) ? line_act_s : C_ZERO;
            end else if (hs_fall_s) begin
                vcnt_r <= sat_inc(vcnt_r);
                lcnt_r <= act_nz_s ? sat_inc(lcnt_r) : lcnt_r;
                if (act_nz_s && !first_seen_r) begin
                    first_seen_r <= 1'b1;
                    first_act_r  <= line_act_s;
                end
            end
        end
    end

    // Pixel coordinates and frame_start, aligned with the stage-2 pixel
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            x           <= C_ZERO;
            y           <= C_ZERO;
            frame_start <= 1'b0;
        end else begin
            frame_start <= vs_fall_s;
            if (vs_fall_s) begin
                x <= C_ZERO;
                y <= C_ZERO;
            end else if (bl_fall_s) begin
                x <= C_ZERO;
                y <= sat_inc(y);
            end else if (pixel_valid) begin
                x <= sat_inc(x);
            end
        end
    end

    // Lock FSM next-state logic
    always_comb begin
        state_n_s = state_r;
        mcnt_n_s  = mcnt_r;
        err_inc_s = 1'b0;
        latch_s   = 1'b0;
        if (sat_s) begin
            state_n_s = SEARCH;
            err_inc_s = (state_r == LOCKED);
        end else begin
            case (state_r)
                SEARCH: begin
                    if (vs_fall_s) state_n_s = MEASURE;
                    else           state_n_s = SEARCH;
                end
                MEASURE: begin
                    if (vs_fall_s) begin
                        state_n_s = VERIFY;
                        mcnt_n_s  = 8'd0;
                        latch_s   = 1'b1;
                    end else begin
                        state_n_s = MEASURE;
                    end
                end
                VERIFY: begin
                    if (line_bad_s || frame_bad_s) begin
                        state_n_s = SEARCH;
                    end else if (vs_fall_s) begin
                        mcnt_n_s = mcnt_r + 8'd1;
                        if (mcnt_r + 8'd1 >= LOCK_N) state_n_s = LOCKED;
                        else                         state_n_s = VERIFY;
                    end else begin
                        state_n_s = VERIFY;
                    end
                end
                LOCKED: begin
                    if (line_bad_s || frame_bad_s) begin
                        state_n_s = SEARCH;
                        err_inc_s = 1'b1;
                    end else begin
                        state_n_s = LOCKED;
                    end
                end
                default: state_n_s = SEARCH;
            endcase
        end
    end

    // Lock FSM state, reference measurements and error counter
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            state_r   <= SEARCH;
            mcnt_r    <= 8'd0;
            locked    <= 1'b0;
            err_count <= 8'd0;
            h_total   <= C_ZERO;
            v_total   <= C_ZERO;
            h_active  <= C_ZERO;
            v_active  <= C_ZERO;
        end else begin
            state_r <= state_n_s;
            mcnt_r  <= mcnt_n_s;
            locked  <= (state_n_s == LOCKED);
            if (err_inc_s && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (latch_s) begin
                h_total  <= hs_fall_s ? line_len_s : line_len_r;
                v_total  <= vcnt_r;
                h_active <= first_act_r;
                v_active <= lcnt_r;
            end
        end
    end

endmodule
